// File: rtl/hilo_div_ctrl_if.sv
// Bundle of control-unit, divider and HI/LO access signals for hilo_div_ctrl.
// slave is the sequencer's view; master is the surrounding control/datapath view.
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] div_lo_in;
    logic [WIDTH-1:0] div_hi_in;
    logic             divby0flag;
    logic             divOp;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_busy;
    logic             div_done;
    logic             div_zero_exc;

    modport slave (
        input  div_start,
        input  div_lo_in,
        input  div_hi_in,
        input  divby0flag,
        input  mthi,
        input  mtlo,
        input  wr_data,
        output divOp,
        output hi_out,
        output lo_out,
        output div_busy,
        output div_done,
        output div_zero_exc
    );

    modport master (
        output div_start,
        output div_lo_in,
        output div_hi_in,
        output divby0flag,
        output mthi,
        output mtlo,
        output wr_data,
        input  divOp,
        input  hi_out,
        input  lo_out,
        input  div_busy,
        input  div_done,
        input  div_zero_exc
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequences the iterative divider, owns the architectural HI/LO registers and
// services mthi/mtlo writes; raises a pulse on completion or divide-by-zero.
module hilo_div_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    hilo_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

    state_t           state, state_n;
    logic [5:0]       cnt, cnt_n;
    logic             div_op_q, div_op_n;
    logic             done_q, done_n;
    logic             exc_q, exc_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH-1:0] lo_q, lo_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            div_op_q <= 1'b0;
            done_q   <= 1'b0;
            exc_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_op_q <= div_op_n;
            done_q   <= done_n;
            exc_q    <= exc_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        div_op_n = 1'b0;
        done_n   = 1'b0;
        exc_n    = 1'b0;
        hi_n     = hi_q;
        lo_n     = lo_q;

        if (bus.mthi) begin
            hi_n = bus.wr_data;
        end
        if (bus.mtlo) begin
            lo_n = bus.wr_data;
        end

        case (state)
            IDLE: begin
                if (bus.div_start) begin
                    state_n  = RUN;
                    cnt_n    = 6'd0;
                    div_op_n = 1'b1;
                end
            end
            RUN: begin
                cnt_n    = cnt + 6'd1;
                div_op_n = 1'b1;
                // The divider only reports a zero divisor meaningfully on its first iteration.
                if ((cnt == 6'd0) && bus.divby0flag) begin
                    state_n  = IDLE;
                    cnt_n    = 6'd0;
                    div_op_n = 1'b0;
                    exc_n    = 1'b1;
                end else if (cnt == LAST_CNT) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                // Division result overrides any concurrent mthi/mtlo.
                hi_n     = bus.div_hi_in;
                lo_n     = bus.div_lo_in;
                done_n   = 1'b1;
                state_n  = IDLE;
                cnt_n    = 6'd0;
                div_op_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 6'd0;
            end
        endcase
    end

    assign bus.divOp        = div_op_q;
    assign bus.div_done     = done_q;
    assign bus.div_zero_exc = exc_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;
    assign bus.div_busy     = (state == RUN) || (state == CAPTURE);

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a behavioural 32-iteration divider model.
module tb_hilo_div_ctrl;

    logic clk;
    logic reset;

    hilo_div_ctrl_if #(.WIDTH(32)) bus ();

    hilo_div_ctrl #(
        .WIDTH      (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: results appear only after 32 edges with divOp high; divOp low clears it.
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [5:0]  divCount = 6'd0;

    always @(posedge clk) begin
        if (bus.divOp !== 1'b1) divCount <= 6'd0;
        else if (divCount < 6'd32) divCount <= divCount + 6'd1;
    end

    assign bus.div_lo_in  = (divCount == 6'd32 && divisor != 0) ? dividend / divisor : 32'hA5A5_A5A5;
    assign bus.div_hi_in  = (divCount == 6'd32 && divisor != 0) ? dividend % divisor : 32'h5A5A_5A5A;
    assign bus.divby0flag = (bus.divOp === 1'b1) && (divisor == 32'd0);

    int checks;
    int failures;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        dividend      = a;
        divisor       = b;
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.div_start = 1'b0;
        bus.mthi      = 1'b0;
        bus.mtlo      = 1'b0;
        bus.wr_data   = 32'h0;
        dividend      = 32'd0;
        divisor       = 32'd1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_hilo: got hi=%h lo=%h expected 0/0", bus.hi_out, bus.lo_out);
        end
        checks++;
        if ({bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got op/busy/done/exc=%b expected 0000",
                     {bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc});
        end
    endtask

    task automatic test_basic_div();
        int opCycles;
        int earlyPulses;
        start_div(32'd100, 32'd7);
        checks++;
        if ({bus.divOp, bus.div_busy} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL basic_start: got op/busy=%b expected 11", {bus.divOp, bus.div_busy});
        end
        opCycles    = 1;
        earlyPulses = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (bus.divOp === 1'b1) opCycles++;
            if (bus.div_done !== 1'b0 || bus.div_zero_exc !== 1'b0) earlyPulses++;
        end
        checks++;
        if (earlyPulses !== 0 || bus.div_busy !== 1'b1 || bus.lo_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL basic_e32: got pulses=%0d busy=%b lo=%0d expected 0/1/0",
                     earlyPulses, bus.div_busy, bus.lo_out);
        end
        tick();
        if (bus.divOp === 1'b1) opCycles++;
        checks++;
        if (bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2) begin
            failures++;
            $display("[TB] FAIL basic_result: got lo=%0d hi=%0d expected 14/2", bus.lo_out, bus.hi_out);
        end
        checks++;
        if ({bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL basic_e33_ctrl: got op/busy/done/exc=%b expected 0010",
                     {bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc});
        end
        checks++;
        if (opCycles !== 33) begin
            failures++;
            $display("[TB] FAIL basic_op_cycles: got %0d expected 33", opCycles);
        end
        tick();
        checks++;
        if (bus.div_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_done_clear: got %b expected 0", bus.div_done);
        end
    endtask

    task automatic test_div_by_zero();
        int donePulses;
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'h0;
        tick();
        bus.mtlo    = 1'b0;
        bus.wr_data = 32'hDEAD_BEEF;
        tick();
        bus.mthi = 1'b0;
        checks++;
        if (bus.hi_out !== 32'hDEAD_BEEF || bus.lo_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mt_preload: got hi=%h lo=%h expected deadbeef/0", bus.hi_out, bus.lo_out);
        end
        start_div(32'd55, 32'd0);
        checks++;
        if ({bus.divOp, bus.div_zero_exc} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL dz_e0: got op/exc=%b expected 10", {bus.divOp, bus.div_zero_exc});
        end
        tick();
        checks++;
        if ({bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL dz_e1_ctrl: got op/busy/done/exc=%b expected 0001",
                     {bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc});
        end
        checks++;
        if (bus.hi_out !== 32'hDEAD_BEEF || bus.lo_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL dz_hilo: got hi=%h lo=%h expected deadbeef/0", bus.hi_out, bus.lo_out);
        end
        donePulses = 0;
        tick();
        checks++;
        if (bus.div_zero_exc !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dz_exc_clear: got %b expected 0", bus.div_zero_exc);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done !== 1'b0 || bus.div_busy !== 1'b0) donePulses++;
            tick();
        end
        checks++;
        if (donePulses !== 0) begin
            failures++;
            $display("[TB] FAIL dz_quiet: got %0d busy/done cycles expected 0", donePulses);
        end
    endtask

    task automatic test_back_to_back();
        int donePulses;
        start_div(32'd50, 32'd5);
        donePulses = 0;
        for (int i = 1; i <= 33; i++) begin
            if (i == 5) begin
                bus.mthi    = 1'b1;
                bus.wr_data = 32'hCAFE_0001;
            end
            if (i == 10) bus.div_start = 1'b1;
            tick();
            bus.div_start = 1'b0;
            bus.mthi      = 1'b0;
            if (bus.div_done === 1'b1) donePulses++;
            if (i == 5) begin
                checks++;
                if (bus.hi_out !== 32'hCAFE_0001) begin
                    failures++;
                    $display("[TB] FAIL b2b_mthi_busy: got %h expected cafe0001", bus.hi_out);
                end
            end
            if (i == 10) begin
                checks++;
                if ({bus.divOp, bus.div_busy} !== 2'b11) begin
                    failures++;
                    $display("[TB] FAIL b2b_e10: got op/busy=%b expected 11", {bus.divOp, bus.div_busy});
                end
            end
            if (i == 33) begin
                checks++;
                if (bus.div_done !== 1'b1 || bus.lo_out !== 32'd10 || bus.hi_out !== 32'd0) begin
                    failures++;
                    $display("[TB] FAIL b2b_e33: got done=%b lo=%0d hi=%0d expected 1/10/0",
                             bus.div_done, bus.lo_out, bus.hi_out);
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.div_done === 1'b1) donePulses++;
        end
        checks++;
        if (donePulses !== 1 || bus.div_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_single_done: got pulses=%0d busy=%b expected 1/0", donePulses, bus.div_busy);
        end
    endtask

    task automatic test_capture_collision();
        start_div(32'd9, 32'd4);
        for (int i = 1; i <= 32; i++) tick();
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'h1234_5678;
        tick();
        checks++;
        if (bus.lo_out !== 32'd2 || bus.hi_out !== 32'd1 || bus.div_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL collide_capture: got lo=%h hi=%h done=%b expected 2/1/1",
                     bus.lo_out, bus.hi_out, bus.div_done);
        end
        tick();
        bus.mtlo = 1'b0;
        checks++;
        if (bus.lo_out !== 32'h1234_5678 || bus.hi_out !== 32'd1) begin
            failures++;
            $display("[TB] FAIL collide_mtlo_after: got lo=%h hi=%h expected 12345678/1",
                     bus.lo_out, bus.hi_out);
        end
    endtask

    task automatic test_reset_mid_div();
        start_div(32'd100, 32'd7);
        for (int i = 1; i <= 14; i++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midreset_ctrl: got op/busy/done/exc=%b expected 0000",
                     {bus.divOp, bus.div_busy, bus.div_done, bus.div_zero_exc});
        end
        checks++;
        if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL midreset_hilo: got hi=%h lo=%h expected 0/0", bus.hi_out, bus.lo_out);
        end
        reset = 1'b1;
        tick();
        start_div(32'd100, 32'd7);
        for (int i = 1; i <= 33; i++) tick();
        checks++;
        if (bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2 || bus.div_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_rerun: got lo=%0d hi=%0d done=%b expected 14/2/1",
                     bus.lo_out, bus.hi_out, bus.div_done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_div();
        test_div_by_zero();
        test_back_to_back();
        test_capture_collision();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
Sequencer and HI/LO register pair that sits directly downstream of the 32-cycle iterative divider. On a start request from the main control unit it drives the divider's divOp enable and counts its iterations. It then captures div_hi/div_lo into the architectural HI/LO registers, or aborts with a divide-by-zero exception. The same block also services mthi/mtlo writes and provides HI/LO to the mfhi/mflo datapath mux.

Parameters:
WIDTH, 32, data width of HI, LO and divider results
DIV_CYCLES, 32, divider iterations: number of rising edges with divOp=1 before div_hi/div_lo are valid

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
div_start  input  1  one-cycle request from control unit to begin a division
div_lo_in  input  WIDTH  quotient from divider (div_lo)
div_hi_in  input  WIDTH  remainder from divider (div_hi)
divby0flag  input  1  divider flag, combinational: divisor==0 and divOp
divOp  output  1  registered enable to divider; 0 clears divider internal state
mthi  input  1  write wr_data into HI
mtlo  input  1  write wr_data into LO
wr_data  input  WIDTH  data for mthi/mtlo
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register
div_busy  output  1  high while in RUN or CAPTURE
div_done  output  1  one-cycle pulse when HI/LO have been updated by a division
div_zero_exc  output  1  one-cycle pulse on divide-by-zero abort

Behaviour:
- Reset, sampled at a rising edge with reset=0:
  - state=IDLE, cnt=0.
  - divOp, div_busy, div_done, div_zero_exc, hi_out and lo_out all 0.
  - Reset overrides every other input, including mid-division. divOp=0 in the following cycle clears the divider.
- States: IDLE, RUN, CAPTURE. 6-bit counter cnt.
- IDLE:
  - div_start=1 at edge E0 -> RUN, cnt=0, divOp=1.
  - Otherwise stay in IDLE with divOp=0.
- RUN: divOp=1. Each edge increments cnt.
  - Edge E1 (cnt==0): if divby0flag=1 -> IDLE, divOp=0, div_zero_exc=1 for one cycle. HI/LO unchanged.
  - At the edge where cnt==DIV_CYCLES-1 (edge E32): -> CAPTURE. The divider outputs are valid after this edge.
- CAPTURE: divOp held at 1; the divider holds its outputs once its count is exhausted.
  - Edge E33: hi_out<=div_hi_in, lo_out<=div_lo_in, div_done=1 for one cycle, -> IDLE, divOp=0.
  - Total latency: 33 edges from the edge sampling div_start to the HI/LO update.
- div_busy is 1 in RUN and CAPTURE, combinational from state.
- div_start while div_busy=1 is ignored (no queueing, no restart).
- mthi/mtlo:
  - Write takes effect at the next edge in any state.
  - If a CAPTURE update coincides with mthi or mtlo, the division result wins for both registers.
  - mthi and mtlo together write both registers with wr_data.
- div_done and div_zero_exc are never high in the same cycle. Each is a single-cycle pulse, cleared on the next edge.
- No arithmetic is performed here. Captured values are the exact bit patterns presented by the divider.

Test Plan:
- Reset with reset=0 for 2 edges, then release -> hi_out=0, lo_out=0, divOp=0, div_busy=0, no pulses.
- div_start pulse, divider with dividend=100 and divisor=7 -> divOp high for 33 cycles. At edge E33 lo_out=14, hi_out=2, div_done pulses once, then divOp=0 and div_busy=0.
- Pre-load HI=0xDEADBEEF via mthi, then div_start with divisor=0 -> div_zero_exc pulses after E1. hi_out=0xDEADBEEF and lo_out=0 retained, no div_done, back in IDLE with divOp=0.
- Pulse div_start again at E10 during a division of 50/5 -> ignored. Single div_done at E33 with lo_out=10, hi_out=0.
- mtlo with wr_data=0x12345678 on the same edge as the CAPTURE of 9/4 -> lo_out=2 and hi_out=1 (division wins). An mtlo one cycle later -> lo_out=0x12345678.
- Assert reset=0 at E15 of a division -> at the next edge state=IDLE, divOp=0, HI/LO=0, no pulses. A fresh div_start of 100/7 then completes normally with LO=14, HI=2.
